pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register, optional skid entry (PIPE_STAGE_SKID_EN)
// Bubbles present all-zero data/ctrl so a downstream stage sees them as NOPs.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              main_free;

    // in_ready comes straight from the skid flop, so out_ready never reaches it.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
        end
    end

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`else
    assign in_ready = ~main_valid | out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (in_ready) begin
            main_valid <= in_valid;
            if (in_valid) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end
        end
    end

    assign occupancy = {1'b0, main_valid};
`endif

    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : '0;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg (both PIPE_STAGE_SKID_EN builds)
module tb_pipe_stage_reg;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_ctrl;
    logic [1:0]  occupancy;

    int vectors;
    int miscompares;

`ifdef PIPE_STAGE_SKID_EN
    localparam logic [1:0] FULL_OCC = 2'd2;
`else
    localparam logic [1:0] FULL_OCC = 2'd1;
`endif

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = 16'hA5A5;
        step(); step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", out_valid); end
        vectors++; if (out_data !== 32'd0) begin miscompares++; $display("FAIL rst_data got %h want 0", out_data); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL rst_occ got %0d want 0", occupancy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", in_ready); end
        reset = 1'b0;
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rst_first got v=%b d=%h want v=1 d=deadbeef", out_valid, out_data); end
        vectors++; if (out_ctrl !== 16'hA5A5) begin miscompares++; $display("FAIL rst_first_ctrl got %h want a5a5", out_ctrl); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL rst_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            in_ctrl = 16'(i * 3);
            step();
            vectors++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin miscompares++; $display("FAIL stream_data[%0d] got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, i); end
            vectors++; if (out_ctrl !== 16'(i * 3)) begin miscompares++; $display("FAIL stream_ctrl[%0d] got %0d want %0d", i, out_ctrl, i * 3); end
            vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_ctrl !== 16'd0) begin miscompares++; $display("FAIL stream_bubble got v=%b d=%h c=%h want all 0", out_valid, out_data, out_ctrl); end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd5; in_ctrl = 16'h0005;
        step();
        vectors++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_one got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
        in_data = 32'd6; in_ctrl = 16'h0006;
        step();
        vectors++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_two got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
        vectors++; if (out_data !== 32'd5) begin miscompares++; $display("FAIL bp_head got %0d want 5", out_data); end
        in_data = 32'd9; in_ctrl = 16'h0009;
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_comb got %b want 0", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_data !== 32'd6 || out_ctrl !== 16'h0006) begin miscompares++; $display("FAIL bp_second got d=%0d c=%h want d=6 c=0006", out_data, out_ctrl); end
        vectors++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL bp_blocked got v=%b occ=%0d d=%0d want v=0 occ=0", out_valid, occupancy, out_data); end
    endtask
`else
    task automatic test_nonskid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd11; in_ctrl = 16'h0011;
        step();
        vectors++; if (occupancy !== 2'd1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL ns_stall got occ=%0d rdy=%b want occ=1 rdy=0", occupancy, in_ready); end
        in_data = 32'd12; in_ctrl = 16'h0012;
        step();
        vectors++; if (out_data !== 32'd11 || occupancy !== 2'd1) begin miscompares++; $display("FAIL ns_hold got d=%0d occ=%0d want d=11 occ=1", out_data, occupancy); end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ns_ready_comb got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_data !== 32'd12 || out_ctrl !== 16'h0012) begin miscompares++; $display("FAIL ns_b2b got d=%0d c=%h want d=12 c=0012", out_data, out_ctrl); end
        step();
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL ns_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask
`endif

    task automatic fill_stage();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd1; in_ctrl = 16'h0101;
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 32'd2; in_ctrl = 16'h0202;
        step();
`endif
        in_valid = 1'b0;
        vectors++; if (occupancy !== FULL_OCC) begin miscompares++; $display("FAIL fill_occ got %0d want %0d", occupancy, FULL_OCC); end
    endtask

    task automatic test_flush();
        fill_stage();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'd7; in_ctrl = 16'h0777;
        out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_clear got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); end
        vectors++; if (out_ctrl !== 16'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_nop got c=%h rdy=%b want c=0 rdy=1", out_ctrl, in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (out_valid !== 1'b0 || out_data === 32'd7) begin miscompares++; $display("FAIL flush_drop[%0d] got v=%b d=%0d want v=0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_async_reset();
        fill_stage();
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_ctrl !== 16'd0) begin miscompares++; $display("FAIL areset_out got v=%b d=%h c=%h want all 0", out_valid, out_data, out_ctrl); end
        vectors++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_state got occ=%0d rdy=%b want occ=0 rdy=1", occupancy, in_ready); end
        #1;
        reset = 1'b0;
        in_valid = 1'b1; in_data = 32'd33; in_ctrl = 16'h0033;
        step();
        in_valid = 1'b0;
        vectors++; if (out_data !== 32'd33 || occupancy !== 2'd1) begin miscompares++; $display("FAIL areset_after got d=%0d occ=%0d want d=33 occ=1", out_data, occupancy); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_drain got v=%b want 0", out_valid); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        test_reset();
        test_streaming();
`ifdef PIPE_STAGE_SKID_EN
        test_backpressure();
`else
        test_nonskid();
`endif
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
